alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
// - Execute-entry pipeline register directly upstream of the ALU.
// - Captures decoded operands and ALU control from decode; resolves RAW hazards via EX/WB forwarding.
// - Selects rs1/PC and rs2/imm; drives alu_src1, alu_src2, ALU_Ctrl, add_sub_sel from registers.
// - Valid/ready handshake on both sides; stall and flush for branch redirect.
// PARAMETERS
// XLEN    32  datapath width
// REG_AW  5   register index width
// PORTS
// clk           in   1       rising-edge clock
// reset         in   1       synchronous, active-high reset
// in_valid      in   1       decode holds a valid instruction
// in_ready      out  1       stage can accept this cycle
// in_pc         in   XLEN    instruction PC
// in_rs1        in   REG_AW  rs1 index
// in_rs2        in   REG_AW  rs2 index
// in_rs1_data   in   XLEN    register-file read data, rs1
// in_rs2_data   in   XLEN    register-file read data, rs2
// in_imm        in   XLEN    sign-extended immediate
// in_src1_pc    in   1       1: src1=PC, 0: src1=rs1
// in_src2_imm   in   1       1: src2=imm, 0: src2=rs2
// in_ALU_Ctrl   in   4       ALU operation code (0000 add, 1000 sub, 0110 or, 0111 and, 0100 xor)
// in_add_sub    in   1       add/sub select, passed through
// in_rd         in   REG_AW  destination register
// in_reg_write  in   1       instruction writes rd
// ex_reg_write  in   1       EX-stage producer writes ex_rd
// ex_rd         in   REG_AW  EX-stage destination
// ex_result     in   XLEN    EX-stage result
// wb_reg_write  in   1       WB-stage producer writes wb_rd
// wb_rd         in   REG_AW  WB-stage destination
// wb_result     in   XLEN    WB-stage result
// flush         in   1       kill held and incoming instruction
// out_valid     out  1       ALU operands valid
// out_ready     in   1       downstream consumes this cycle
// alu_src1      out  XLEN    registered ALU operand 1
// alu_src2      out  XLEN    registered ALU operand 2
// ALU_Ctrl      out  4       registered ALU control
// add_sub_sel   out  1       registered add/sub select
// out_rs2_data  out  XLEN    forwarded rs2 value (store data)
// out_rd        out  REG_AW  registered rd
// out_reg_write out  1       registered reg_write, qualified by out_valid
// BEHAVIOUR
// - Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
// - in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready && !flush.
// - Latency: accepted instruction appears on outputs the next cycle. Full throughput when out_ready=1.
// - EMPTY->FULL on accept.
// - FULL->EMPTY on out_ready && !accept.
// - FULL->FULL on accept (back-to-back), or on !out_ready (hold; outputs stable).
// - flush: next cycle out_valid=0, regardless of in_valid/out_ready; incoming instruction dropped.
// - Reset: out_valid=0 and all data/control outputs 0; reset overrides flush and accept.
// - Forward select per source (rs1, rs2), evaluated at accept:
//   - index==0: value 0, never forwarded.
//   - else ex_reg_write && ex_rd==idx: ex_result (EX has priority over WB).
//   - else wb_reg_write && wb_rd==idx: wb_result.
//   - else: rs*_data.
// - alu_src1 = in_src1_pc ? in_pc : fwd_rs1; alu_src2 = in_src2_imm ? in_imm : fwd_rs2.
// - Hold refresh: in FULL && !out_ready, wb_reg_write && wb_rd==held rsN (N!=0) and that source is
//   register-sourced -> held operand updated to wb_result. Same rule applies to out_rs2_data.
// - Stage holds rs indices and select bits internally for this refresh.
// - All outputs driven from flops; no combinational path from in_* to out_*.
// - out_reg_write is 0 whenever out_valid=0.
// CONFIGURATION
// - FWD_EN defined: forwarding and hold refresh as above.
// - FWD_EN undefined: operands from in_rs*_data only (x0 still forced 0); ex_*/wb_* inputs ignored;
//   no hold refresh. Port list is identical in both builds.
// TESTING
// - Reset 3 cycles, then release -> out_valid=0, alu_src1=alu_src2=0, ALU_Ctrl=0, in_ready=1.
// - Accept add rs1=5 (data 0x10), imm=0x4, src2_imm=1, out_ready=1
//   -> next cycle alu_src1=0x10, alu_src2=0x4, ALU_Ctrl=0000, out_valid=1.
// - rs1=3, ex_rd=3 ex_result=0xAA, wb_rd=3 wb_result=0xBB, rs1_data=0xCC
//   -> alu_src1=0xAA (FWD_EN), 0xCC (no FWD_EN).
// - rs2=0, ex_rd=0, ex_reg_write=1, ex_result=0xFF -> alu_src2=0.
// - FULL with out_ready=0 for 3 cycles, held rs2=7, wb_rd=7 wb_result=0x1234 on cycle 2
//   -> alu_src2=0x1234 from cycle 3; in_ready=0 throughout; ALU_Ctrl stable.
// - FULL with out_ready=0, flush=1 and in_valid=1 same cycle
//   -> next cycle out_valid=0, out_reg_write=0, incoming instruction not delivered.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: execute-entry pipeline register ahead of the ALU.
// Captures decoded operands and control from decode, resolves RAW hazards
// from the EX/WB stages, selects rs1/PC and rs2/imm, and presents the
// result on flops with a valid/ready handshake, stall hold and flush.
//
// Build option: define FWD_EN to enable EX/WB forwarding and the hold-time
// WB refresh. Without FWD_EN, operands come straight from the register-file
// read data (x0 still reads as zero). The port list is the same either way.

// Per-source operand resolver: one instance per ALU register source.
module alu_operand_fwd #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx,          // incoming source index
  input  logic [XLEN-1:0]   rf_data,      // register-file read data
  input  logic [REG_AW-1:0] held_idx,     // index of the held instruction's source
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   fwd_val,      // resolved value for the incoming source
  output logic              refresh_hit   // WB is writing the held source this cycle
);

`ifdef FWD_EN
  // x0 is hard-wired zero; EX is younger than WB so it wins when both match.
  always_comb begin
    fwd_val = rf_data;
    if (idx == '0)
      fwd_val = '0;
    else if (ex_reg_write && (ex_rd == idx))
      fwd_val = ex_result;
    else if (wb_reg_write && (wb_rd == idx))
      fwd_val = wb_result;
  end

  // A stalled operand can go stale if its producer retires from WB meanwhile.
  assign refresh_hit = wb_reg_write && (held_idx != '0) && (wb_rd == held_idx);
`else
  // No bypass network: only the x0 rule remains.
  assign fwd_val     = (idx == '0) ? '0 : rf_data;
  assign refresh_hit = 1'b0;

  logic unused_fwd;
  assign unused_fwd = ^{held_idx, ex_reg_write, ex_rd, ex_result,
                        wb_reg_write, wb_rd, wb_result};
`endif

endmodule

module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_src1_pc,
  input  logic              in_src2_imm,
  input  logic [3:0]        in_ALU_Ctrl,
  input  logic              in_add_sub,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  // bypass sources
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  // redirect
  input  logic              flush,
  // ALU side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_src1,
  output logic [XLEN-1:0]   alu_src2,
  output logic [3:0]        ALU_Ctrl,
  output logic              add_sub_sel,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write
);

  localparam int NUM_SRC = 2;   // source 0 = rs1, source 1 = rs2

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Source bookkeeping kept alongside the held instruction so a stalled
  // operand can be refreshed from WB.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              src1_pc;
    logic              src2_imm;
  } hold_t;

  logic [0:0] state;
  hold_t      hold_q;

  logic [NUM_SRC-1:0][REG_AW-1:0] src_idx;
  logic [NUM_SRC-1:0][REG_AW-1:0] held_idx;
  logic [NUM_SRC-1:0][XLEN-1:0]   src_data;
  logic [NUM_SRC-1:0][XLEN-1:0]   fwd_val;
  logic [NUM_SRC-1:0]             refresh_hit;

  logic full;
  logic accept;
  logic stall;

  assign full      = (state == ST_FULL);
  assign out_valid = full;
  assign in_ready  = !full || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign stall     = full && !out_ready;

  assign src_idx  = {in_rs2, in_rs1};
  assign src_data = {in_rs2_data, in_rs1_data};
  assign held_idx = {hold_q.rs2, hold_q.rs1};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      alu_operand_fwd #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
      ) u_fwd (
        .idx          (src_idx[g]),
        .rf_data      (src_data[g]),
        .held_idx     (held_idx[g]),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd_val      (fwd_val[g]),
        .refresh_hit  (refresh_hit[g])
      );
    end
  endgenerate

  // EMPTY/FULL occupancy: flush kills everything, accept fills, consume drains.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_EMPTY;
    else if (flush)
      state <= ST_EMPTY;
    else if (accept)
      state <= ST_FULL;
    else if (full && out_ready)
      state <= ST_EMPTY;
  end

  // out_reg_write is its own flop, cleared whenever the stage empties, so it
  // can never assert without out_valid.
  always_ff @(posedge clk) begin
    if (reset)
      out_reg_write <= 1'b0;
    else if (flush)
      out_reg_write <= 1'b0;
    else if (accept)
      out_reg_write <= in_reg_write;
    else if (full && out_ready)
      out_reg_write <= 1'b0;
  end

  // Operand/control capture on accept; WB refresh of register-sourced
  // operands while stalled so the held values never go stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      ALU_Ctrl     <= '0;
      add_sub_sel  <= 1'b0;
      out_rs2_data <= '0;
      out_rd       <= '0;
    end else if (accept) begin
      hold_q.rs1      <= in_rs1;
      hold_q.rs2      <= in_rs2;
      hold_q.src1_pc  <= in_src1_pc;
      hold_q.src2_imm <= in_src2_imm;
      alu_src1        <= in_src1_pc  ? in_pc  : fwd_val[0];
      alu_src2        <= in_src2_imm ? in_imm : fwd_val[1];
      ALU_Ctrl        <= in_ALU_Ctrl;
      add_sub_sel     <= in_add_sub;
      out_rs2_data    <= fwd_val[1];
      out_rd          <= in_rd;
    end else if (stall) begin
      if (refresh_hit[0] && !hold_q.src1_pc)
        alu_src1 <= wb_result;
      if (refresh_hit[1] && !hold_q.src2_imm)
        alu_src2 <= wb_result;
      // Store data is always the rs2 register value, whatever src2 selects.
      if (refresh_hit[1])
        out_rs2_data <= wb_result;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset state, operand selection,
// forwarding priority, x0 handling, stall hold with WB refresh, flush, drain.
// Expected values follow the FWD_EN build option when it is defined.
module tb_alu_operand_stage;

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        in_src1_pc;
  logic        in_src2_imm;
  logic [3:0]  in_ALU_Ctrl;
  logic        in_add_sub;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  ALU_Ctrl;
  logic        add_sub_sel;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  int checks;
  int failures;

  alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_src1_pc   (in_src1_pc),
    .in_src2_imm  (in_src2_imm),
    .in_ALU_Ctrl  (in_ALU_Ctrl),
    .in_add_sub   (in_add_sub),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .ALU_Ctrl     (ALU_Ctrl),
    .add_sub_sel  (add_sub_sel),
    .out_rs2_data (out_rs2_data),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_bypass();
    ex_reg_write = 1'b0; ex_rd = 5'd0; ex_result = 32'h0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_pc = 32'h0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_rs1_data = 32'h0; in_rs2_data = 32'h0; in_imm = 32'h0;
    in_src1_pc = 1'b0; in_src2_imm = 1'b0; in_ALU_Ctrl = 4'h0;
    in_add_sub = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0;
    clear_bypass();

    // reset 3 cycles, then release
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_src1", alu_src1, 32'h0);
    chk("rst_src2", alu_src2, 32'h0);
    chk("rst_ctrl", 32'(ALU_Ctrl), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_rw", 32'(out_reg_write), 32'h0);

    // A: add x5(0x10) + imm 4
    in_valid = 1'b1; out_ready = 1'b1;
    in_rs1 = 5'd5; in_rs1_data = 32'h10; in_rs2 = 5'd6; in_rs2_data = 32'h66;
    in_imm = 32'h4; in_src2_imm = 1'b1; in_ALU_Ctrl = 4'b0000;
    in_rd = 5'd1; in_reg_write = 1'b1;
    step();
    chk("a_valid", 32'(out_valid), 32'h1);
    chk("a_src1", alu_src1, 32'h10);
    chk("a_src2", alu_src2, 32'h4);
    chk("a_ctrl", 32'(ALU_Ctrl), 32'h0);
    chk("a_rd", 32'(out_rd), 32'h1);
    chk("a_rw", 32'(out_reg_write), 32'h1);

    // B: rs1=3 matches EX and WB; EX wins. rs2=0 reads zero.
    in_rs1 = 5'd3; in_rs1_data = 32'hCC; in_rs2 = 5'd0; in_rs2_data = 32'h55;
    in_src2_imm = 1'b0; in_ALU_Ctrl = 4'b1000; in_add_sub = 1'b1; in_rd = 5'd2;
    ex_reg_write = 1'b1; ex_rd = 5'd3; ex_result = 32'hAA;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
    step();
    chk("b_src1_fwd", alu_src1, FWD ? 32'hAA : 32'hCC);
    chk("b_src2_x0", alu_src2, 32'h0);
    chk("b_ctrl", 32'(ALU_Ctrl), 32'h8);
    chk("b_addsub", 32'(add_sub_sel), 32'h1);

    // C: rs2=0 with EX writing x0 stays zero; rs1 from WB only
    in_rs1 = 5'd4; in_rs1_data = 32'h44; in_rs2 = 5'd0; in_rs2_data = 32'h33;
    in_ALU_Ctrl = 4'b0100; in_add_sub = 1'b0;
    ex_reg_write = 1'b1; ex_rd = 5'd0; ex_result = 32'hFF;
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'h99;
    step();
    chk("c_src1_wb", alu_src1, FWD ? 32'h99 : 32'h44);
    chk("c_src2_x0", alu_src2, 32'h0);
    chk("c_rs2data_x0", out_rs2_data, 32'h0);

    // D: src1 = PC, src2 = rs2 register
    clear_bypass();
    in_src1_pc = 1'b1; in_pc = 32'h1000; in_rs1 = 5'd8; in_rs1_data = 32'h88;
    in_rs2 = 5'd6; in_rs2_data = 32'h66; in_ALU_Ctrl = 4'b0110;
    step();
    chk("d_src1_pc", alu_src1, 32'h1000);
    chk("d_src2_rs2", alu_src2, 32'h66);
    chk("d_ctrl", 32'(ALU_Ctrl), 32'h6);

    // E: rs2=7 register-sourced, then stall
    in_src1_pc = 1'b0; in_rs1 = 5'd2; in_rs1_data = 32'h20;
    in_rs2 = 5'd7; in_rs2_data = 32'h70; in_ALU_Ctrl = 4'b0111;
    in_rd = 5'd9; in_reg_write = 1'b1;
    step();
    chk("e_src2", alu_src2, 32'h70);
    chk("e_src1", alu_src1, 32'h20);
    // stall with a competing instruction F offered
    out_ready = 1'b0;
    in_rs2 = 5'd7; in_rs2_data = 32'h999; in_ALU_Ctrl = 4'b0100; in_rd = 5'd10;
    #1;
    chk("hold_ready0", 32'(in_ready), 32'h0);
    step();
    chk("hold1_src2", alu_src2, 32'h70);
    chk("hold1_ready", 32'(in_ready), 32'h0);
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'h1234;
    step();
    chk("hold2_src2", alu_src2, FWD ? 32'h1234 : 32'h70);
    chk("hold2_rs2data", out_rs2_data, FWD ? 32'h1234 : 32'h70);
    chk("hold2_src1", alu_src1, 32'h20);
    chk("hold2_ctrl", 32'(ALU_Ctrl), 32'h7);
    clear_bypass();
    step();
    chk("hold3_src2", alu_src2, FWD ? 32'h1234 : 32'h70);
    chk("hold3_ctrl", 32'(ALU_Ctrl), 32'h7);
    chk("hold3_valid", 32'(out_valid), 32'h1);
    chk("hold3_rd", 32'(out_rd), 32'h9);
    chk("hold3_ready", 32'(in_ready), 32'h0);

    // flush while stalled with in_valid high
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_rw", 32'(out_reg_write), 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'h1);
    step();
    chk("flush_nodeliver", 32'(out_valid), 32'h0);

    // G: EX forward on rs1, negative immediate; then drain
    in_valid = 1'b1;
    in_rs1 = 5'd1; in_rs1_data = 32'h11; in_imm = 32'hFFFF_FFFC; in_src2_imm = 1'b1;
    in_ALU_Ctrl = 4'b1000; in_rd = 5'd2; in_reg_write = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd1; ex_result = 32'h5;
    step();
    chk("g_src1", alu_src1, FWD ? 32'h5 : 32'h11);
    chk("g_src2", alu_src2, 32'hFFFF_FFFC);
    chk("g_rw", 32'(out_reg_write), 32'h1);
    in_valid = 1'b0; clear_bypass();
    step();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_rw", 32'(out_reg_write), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
